// File: rtl/box_region_scanner.sv
// Raster scan of the pixels inside a latched selection box.
// Emits one coordinate/address beat per pixel over a valid/ready stream.
module box_region_scanner #(
    parameter int unsigned IMAGE_WIDTH  = 1080,
    parameter int unsigned IMAGE_HEIGHT = 1920,
    parameter int unsigned COORD_W      = 11,
    parameter int unsigned ADDR_W       = 21,
    parameter int unsigned CNT_W        = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic               pix_last,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pix_count
);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    localparam logic [COORD_W-1:0] XMAX     = COORD_W'(IMAGE_WIDTH - 1);
    localparam logic [COORD_W-1:0] YMAX     = COORD_W'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(IMAGE_WIDTH);

    state_t             state;
    logic [COORD_W-1:0] bx1, by1, bx2, by2;
    logic [COORD_W-1:0] xs_r, xe_r, ye_r;
    logic [ADDR_W-1:0]  row_base;

    // Box normalisation from the latched corners (used in SETUP)
    logic [COORD_W-1:0] nxs, nxe, nys, nye, nxe_raw, nye_raw;
    logic [ADDR_W-1:0]  setup_base;
    logic               box_empty;

    always_comb begin
        nxs        = (bx1 < bx2) ? bx1 : bx2;
        nxe_raw    = (bx1 < bx2) ? bx2 : bx1;
        nys        = (by1 < by2) ? by1 : by2;
        nye_raw    = (by1 < by2) ? by2 : by1;
        nxe        = (nxe_raw > XMAX) ? XMAX : nxe_raw;
        nye        = (nye_raw > YMAX) ? YMAX : nye_raw;
        box_empty  = (nxs > XMAX) || (nys > YMAX);
        setup_base = ADDR_W'(nys) * ROW_STEP;
    end

    // Next raster position after an accepted beat; row wrap uses an add, not a multiply
    logic [COORD_W-1:0] step_x, step_y;
    logic [ADDR_W-1:0]  step_addr, step_base;
    logic               step_last;
    logic               fire;

    always_comb begin
        step_x    = pix_x;
        step_y    = pix_y;
        step_addr = pix_addr;
        step_base = row_base;
        if (pix_x < xe_r) begin
            step_x    = pix_x + COORD_W'(1);
            step_addr = pix_addr + ADDR_W'(1);
        end else begin
            step_x    = xs_r;
            step_y    = pix_y + COORD_W'(1);
            step_base = row_base + ROW_STEP;
            step_addr = row_base + ROW_STEP + ADDR_W'(xs_r);
        end
        step_last = (step_x == xe_r) && (step_y == ye_r);
        fire      = pix_valid && pix_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bx1       <= '0;
            by1       <= '0;
            bx2       <= '0;
            by2       <= '0;
            xs_r      <= '0;
            xe_r      <= '0;
            ye_r      <= '0;
            row_base  <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_addr  <= '0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bx1       <= x1;
                        by1       <= y1;
                        bx2       <= x2;
                        by2       <= y2;
                        pix_count <= '0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (box_empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        xs_r      <= nxs;
                        xe_r      <= nxe;
                        ye_r      <= nye;
                        pix_x     <= nxs;
                        pix_y     <= nys;
                        row_base  <= setup_base;
                        pix_addr  <= setup_base + ADDR_W'(nxs);
                        pix_last  <= (nxs == nxe) && (nys == nye);
                        pix_valid <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (fire) begin
                        pix_count <= pix_count + CNT_W'(1);
                    end
                    if (abort) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (fire) begin
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            pix_x    <= step_x;
                            pix_y    <= step_y;
                            pix_addr <= step_addr;
                            row_base <= step_base;
                            pix_last <= step_last;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_box_region_scanner.sv
// Directed and randomized scans of box_region_scanner against a loop-based
// model of the expected pixel sequence.
module tb_box_region_scanner;

    localparam int W = 1080;
    localparam int H = 1920;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [10:0] pix_x, pix_y;
    logic [20:0] pix_addr;
    logic        pix_last;
    logic        busy;
    logic        done;
    logic [21:0] pix_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int x;
        int y;
        int addr;
        int last;
    } beat_t;

    box_region_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_addr  (pix_addr),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 0);
        check({tag, "_x"},     32'(pix_x), 0);
        check({tag, "_y"},     32'(pix_y), 0);
        check({tag, "_addr"},  32'(pix_addr), 0);
        check({tag, "_last"},  32'(pix_last), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_count"}, 32'(pix_count), 0);
    endtask

    // Expected beats: every pixel of the normalised, clamped, inclusive box in raster order
    task automatic build_expected(input int a1, input int b1, input int a2, input int b2,
                                  output beat_t q[$]);
        int xs, xe, ys, ye;
        beat_t b;
        q = {};
        xs = (a1 < a2) ? a1 : a2;
        xe = (a1 < a2) ? a2 : a1;
        ys = (b1 < b2) ? b1 : b2;
        ye = (b1 < b2) ? b2 : b1;
        if (xe > W - 1) xe = W - 1;
        if (ye > H - 1) ye = H - 1;
        if (xs > W - 1 || ys > H - 1) return;
        for (int yy = ys; yy <= ye; yy++) begin
            for (int xx = xs; xx <= xe; xx++) begin
                b.x    = xx;
                b.y    = yy;
                b.addr = yy * W + xx;
                b.last = (xx == xe && yy == ye) ? 1 : 0;
                q.push_back(b);
            end
        end
    endtask

    // One scan: ready_pct chance of accepting each offered beat; abort_at>0 aborts
    // coincident with that transfer; disturb pulses start and alters x2 mid-scan.
    task automatic run_scan(input int a1, input int b1, input int a2, input int b2,
                            input int ready_pct, input int abort_at, input bit disturb);
        beat_t q[$];
        int    n, idx, cyc;
        bit    expect_done, abort_pending, finished;
        build_expected(a1, b1, a2, b2, q);
        n = q.size();
        @(negedge clk);
        x1 = 11'(a1); y1 = 11'(b1); x2 = 11'(a2); y2 = 11'(b2);
        start = 1'b1; pix_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("setup_busy", 32'(busy), 1);
        check("setup_valid", 32'(pix_valid), 0);
        idx = 0; cyc = 1; expect_done = 0; abort_pending = 0; finished = 0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
            if (abort_pending) begin
                check("abort_valid", 32'(pix_valid), 0);
                check("abort_busy",  32'(busy), 0);
                check("abort_done",  32'(done), 0);
                check("abort_count", 32'(pix_count), 32'(abort_at));
                finished = 1;
            end else if (expect_done || n == 0) begin
                if (n == 0) check("empty_cycle", 32'(cyc), 2);
                check("done_pulse", 32'(done), 1);
                check("done_valid", 32'(pix_valid), 0);
                check("done_busy",  32'(busy), 0);
                check("done_count", 32'(pix_count), 32'(n));
                finished = 1;
            end else begin
                if (cyc == 2) check("first_valid_latency", 32'(pix_valid), 1);
                check("scan_valid", 32'(pix_valid), 1);
                if (pix_valid) begin
                    check("beat_x",    32'(pix_x),    32'(q[idx].x));
                    check("beat_y",    32'(pix_y),    32'(q[idx].y));
                    check("beat_addr", 32'(pix_addr), 32'(q[idx].addr));
                    check("beat_last", 32'(pix_last), 32'(q[idx].last));
                    check("scan_busy", 32'(busy), 1);
                    check("scan_done", 32'(done), 0);
                    if (int'($urandom_range(99)) < ready_pct) begin
                        pix_ready = 1'b1;
                        idx++;
                        if (idx == abort_at) begin
                            abort = 1'b1;
                            abort_pending = 1;
                        end else if (idx == n) begin
                            expect_done = 1;
                        end
                    end
                    if (disturb && idx == 2) begin
                        start = 1'b1;
                        x2 = x2 ^ 11'h00f;
                    end
                end
            end
        end
        if (!finished) check("scan_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        check("post_done_low", 32'(done), 0);
        check("post_valid_low", 32'(pix_valid), 0);
    endtask

    initial begin
        int a1, b1, a2, b2, bx, by;
        // Reset state
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Basic, swapped, backpressured
        run_scan(10, 20, 12, 21, 100, -1, 0);
        run_scan(12, 21, 10, 20, 100, -1, 0);
        run_scan(10, 20, 12, 21, 50, -1, 0);
        // Single pixel, clamp, empty
        run_scan(5, 7, 5, 7, 100, -1, 0);
        run_scan(1078, 0, 2000, 0, 100, -1, 0);
        run_scan(1500, 0, 1600, 0, 100, -1, 0);
        run_scan(3, 1919, 4, 2047, 70, -1, 0);
        run_scan(0, 1925, 2, 1930, 100, -1, 0);
        // Abort after three transfers, then mid-scan start / x2 change ignored
        run_scan(0, 0, 99, 99, 100, 3, 0);
        run_scan(10, 20, 12, 21, 60, -1, 1);
        run_scan(0, 0, 99, 99, 40, 5, 1);

        // Asynchronous reset during a scan
        @(negedge clk);
        x1 = 11'd0; y1 = 11'd0; x2 = 11'd99; y2 = 11'd99; start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_valid", 32'(pix_valid), 1);
        #1 rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1; pix_ready = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
        run_scan(10, 20, 12, 21, 100, -1, 0);

        // Randomized boxes around the frame, including out-of-frame corners
        for (int t = 0; t < 20; t++) begin
            bx = int'($urandom_range(1085));
            by = int'($urandom_range(1925));
            a1 = bx; a2 = bx + int'($urandom_range(5));
            b1 = by; b2 = by + int'($urandom_range(3));
            if ($urandom_range(1) == 1) run_scan(a2, b2, a1, b1, int'($urandom_range(30, 100)), -1, 0);
            else                        run_scan(a1, b2, a2, b1, int'($urandom_range(30, 100)), -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/box_region_scanner.md
Name: box_region_scanner

Overview:
Sequences a raster scan of the pixels inside the selection box produced by the box controller (x1, y1, x2, y2 on an IMAGE_WIDTH x IMAGE_HEIGHT frame). It emits one coordinate/address beat per pixel over a valid/ready stream to the frame-buffer reader that feeds the K-means datapath. It latches the box at start, so button-driven box changes during a scan do not disturb the scan in progress.

Parameters:
IMAGE_WIDTH, 1080, frame width in pixels
IMAGE_HEIGHT, 1920, frame height in pixels
COORD_W, 11, width of coordinate ports
ADDR_W, 21, width of linear pixel address (IMAGE_WIDTH*IMAGE_HEIGHT <= 2^ADDR_W)
CNT_W, 22, width of pixel counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request a scan of the current box; sampled only in IDLE
abort  in  1  terminate the scan in progress
x1  in  COORD_W  box corner 1, column
y1  in  COORD_W  box corner 1, row
x2  in  COORD_W  box corner 2, column
y2  in  COORD_W  box corner 2, row
pix_valid  out  1  beat valid
pix_ready  in  1  downstream accepts beat
pix_x  out  COORD_W  current column
pix_y  out  COORD_W  current row
pix_addr  out  ADDR_W  pix_y*IMAGE_WIDTH + pix_x
pix_last  out  1  current beat is the final pixel of the box
busy  out  1  high in SETUP and SCAN
done  out  1  one-cycle pulse on normal completion
pix_count  out  CNT_W  beats accepted in the current or most recent scan

Behaviour:
- Reset (rst low, asynchronous) forces state IDLE. All outputs are 0, including pix_count and the latched box.
- States: IDLE, SETUP, SCAN, DONE.
- IDLE: when start=1, latch x1..y2, clear pix_count, and go to SETUP. start is ignored in every other state.
- SETUP (1 cycle), box normalisation:
  - xs=min(x1,x2), xe=max(x1,x2); ys and ye likewise.
  - Clamp xe to IMAGE_WIDTH-1 and ye to IMAGE_HEIGHT-1.
  - If xs>IMAGE_WIDTH-1 or ys>IMAGE_HEIGHT-1, the box is empty: go to DONE with no beats.
  - Otherwise load x=xs, y=ys, row_base=ys*IMAGE_WIDTH (constant multiply is allowed here), then go to SCAN.
- Box bounds are inclusive. A box with x1=x2, y1=y2 scans one pixel.
- Latency: start sampled at edge N gives SETUP in cycle N+1 and pix_valid=1 from cycle N+2.
- SCAN: pix_valid=1 and pix_addr=row_base+x.
  - No multiplier is used in SCAN. row_base advances by IMAGE_WIDTH on each row wrap.
- Handshake: a transfer occurs on a rising edge where pix_valid && pix_ready.
  - pix_x, pix_y, pix_addr and pix_last hold stable while pix_valid && !pix_ready.
  - pix_valid never drops without a transfer, except on abort or reset.
- On each transfer, pix_count increments, then:
  - if x<xe: x++.
  - else if y<ye: x=xs, y++, row_base+=IMAGE_WIDTH.
  - else (pix_last=1): go to DONE.
- pix_last = (x==xe && y==ye) while in SCAN.
- Throughput is one beat per cycle with pix_ready held high; there are no bubbles across row wraps.
- DONE (1 cycle): done=1, busy=0, pix_valid=0, then go to IDLE. pix_count holds until the next start.
- abort=1 in SETUP or SCAN: next state is IDLE, pix_valid=0 the following cycle, and no done pulse.
  - If abort coincides with a transfer, that transfer counts in pix_count.
  - abort in IDLE or DONE has no effect.
- Input box changes after the start cycle have no effect until the next start.
- busy=1 exactly in SETUP and SCAN.

Test Plan:
- Basic scan: box (10,20),(12,21), pix_ready=1, pulse start → 6 consecutive beats (10,20),(11,20),(12,20),(10,21),(11,21),(12,21).
  - First beat has addr 21610; last beat has addr 22692 with pix_last=1.
  - First valid is 2 cycles after start; done pulses 1 cycle after the last beat; pix_count=6.
- Swapped corners: (12,21),(10,20) → beat sequence identical to the basic scan.
- Backpressure: pix_ready random 50% on the basic box → outputs stable on every stalled cycle, 6 beats, none dropped or duplicated, pix_count=6.
- Clamp and empty:
  - x1=1078, x2=2000, y1=y2=0 → exactly 2 beats, (1078,0) and (1079,0), second with pix_last.
  - x1=1500, x2=1600 → no pix_valid, done pulses 2 cycles after start, pix_count=0.
- Abort and start-while-busy:
  - Box (0,0),(99,99): abort after 3 transfers → pix_valid low next cycle, busy=0, no done, pix_count=3.
  - start pulsed mid-scan is ignored.
  - Changing x2 mid-scan leaves the beat sequence unaffected.
- Reset mid-scan: rst low for 1 cycle during SCAN → all outputs 0 immediately (asynchronous). After release, state is IDLE and a new start scans correctly.
